// File: rtl/hpdcache_flush_line_serializer.sv
// Buffers one flushed cache line and streams it to the memory write-data channel as MEM_DATA_W beats.
// Optional HPDCACHE_FLUSH_SER_SKIP_CLEAN_BEATS_EN: skip beats whose byte-enables are all zero.
module hpdcache_flush_line_serializer #(
    parameter int unsigned LINE_W     = 512,
    parameter int unsigned MEM_DATA_W = 64,
    parameter int unsigned ID_W       = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    line_valid_i,
    output logic                    line_ready_o,
    input  logic [LINE_W-1:0]       line_data_i,
    input  logic [LINE_W/8-1:0]     line_be_i,
    input  logic [ID_W-1:0]         line_id_i,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic [MEM_DATA_W-1:0]   beat_data_o,
    output logic [MEM_DATA_W/8-1:0] beat_be_o,
    output logic [ID_W-1:0]         beat_id_o,
    output logic                    beat_last_o,
    output logic                    busy_o
);

    localparam int unsigned BEATS     = LINE_W / MEM_DATA_W;
    localparam int unsigned BEAT_BE_W = MEM_DATA_W / 8;
    localparam int unsigned PTR_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                                 state_q;
    logic [BEATS-1:0][MEM_DATA_W-1:0]       data_q;
    logic [BEATS-1:0][BEAT_BE_W-1:0]        be_q;
    logic [ID_W-1:0]                        id_q;
    logic [PTR_W-1:0]                       ptr_q;

    logic                                   line_fire;
    logic                                   beat_fire;
    logic                                   last_c;
    logic [PTR_W-1:0]                       first_ptr_c;
    logic [PTR_W-1:0]                       next_ptr_c;

`ifdef HPDCACHE_FLUSH_SER_SKIP_CLEAN_BEATS_EN
    logic [BEATS-1:0]                       mask_q;
    logic [BEATS-1:0]                       line_mask_c;
    logic [BEATS-1:0][BEAT_BE_W-1:0]        line_be_2d;
    logic                                   has_next_c;

    assign line_be_2d = line_be_i;

    // Descending scans leave the lowest qualifying index; an empty line falls back to beat 0.
    always_comb begin
        line_mask_c = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            line_mask_c[b] = |line_be_2d[b];
        end
        first_ptr_c = '0;
        for (int unsigned b = BEATS; b > 0; b--) begin
            if (line_mask_c[b-1]) first_ptr_c = PTR_W'(b-1);
        end
        next_ptr_c = ptr_q;
        has_next_c = 1'b0;
        for (int unsigned b = BEATS; b > 0; b--) begin
            if (mask_q[b-1] && (PTR_W'(b-1) > ptr_q)) begin
                next_ptr_c = PTR_W'(b-1);
                has_next_c = 1'b1;
            end
        end
    end

    assign last_c = ~has_next_c;
`else
    assign first_ptr_c = '0;
    assign next_ptr_c  = ptr_q + PTR_W'(1);
    assign last_c      = (ptr_q == PTR_W'(BEATS-1));
`endif

    assign beat_valid_o = (state_q == SEND);
    assign busy_o       = (state_q == SEND);
    assign beat_data_o  = data_q[ptr_q];
    assign beat_be_o    = be_q[ptr_q];
    assign beat_id_o    = id_q;
    assign beat_last_o  = beat_valid_o & last_c;

    assign beat_fire    = beat_valid_o & beat_ready_i;
    assign line_ready_o = (state_q == IDLE) | (beat_fire & beat_last_o);
    assign line_fire    = line_valid_i & line_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            data_q  <= '0;
            be_q    <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
`ifdef HPDCACHE_FLUSH_SER_SKIP_CLEAN_BEATS_EN
            mask_q  <= '0;
`endif
        end else begin
            // A line can only fire in SEND together with the last beat, so it takes priority.
            if (line_fire) begin
                state_q <= SEND;
                data_q  <= line_data_i;
                be_q    <= line_be_i;
                id_q    <= line_id_i;
                ptr_q   <= first_ptr_c;
`ifdef HPDCACHE_FLUSH_SER_SKIP_CLEAN_BEATS_EN
                mask_q  <= line_mask_c;
`endif
            end else if (beat_fire) begin
                if (last_c) begin
                    state_q <= IDLE;
                end else begin
                    ptr_q <= next_ptr_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_hpdcache_flush_line_serializer.sv
// Directed bench for hpdcache_flush_line_serializer (default parameters; skip-clean checks follow the macro).
module tb_hpdcache_flush_line_serializer;

    localparam int unsigned LINE_W     = 512;
    localparam int unsigned MEM_DATA_W = 64;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned BEATS      = LINE_W / MEM_DATA_W;

    logic                    clk = 1'b0;
    logic                    rst_ni;
    logic                    line_valid_i;
    logic                    line_ready_o;
    logic [LINE_W-1:0]       line_data_i;
    logic [LINE_W/8-1:0]     line_be_i;
    logic [ID_W-1:0]         line_id_i;
    logic                    beat_valid_o;
    logic                    beat_ready_i;
    logic [MEM_DATA_W-1:0]   beat_data_o;
    logic [MEM_DATA_W/8-1:0] beat_be_o;
    logic [ID_W-1:0]         beat_id_o;
    logic                    beat_last_o;
    logic                    busy_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hpdcache_flush_line_serializer #(
        .LINE_W     (LINE_W),
        .MEM_DATA_W (MEM_DATA_W),
        .ID_W       (ID_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .line_valid_i (line_valid_i),
        .line_ready_o (line_ready_o),
        .line_data_i  (line_data_i),
        .line_be_i    (line_be_i),
        .line_id_i    (line_id_i),
        .beat_valid_o (beat_valid_o),
        .beat_ready_i (beat_ready_i),
        .beat_data_o  (beat_data_o),
        .beat_be_o    (beat_be_o),
        .beat_id_o    (beat_id_o),
        .beat_last_o  (beat_last_o),
        .busy_o       (busy_o)
    );

    // Line whose word k holds base+k, with per-beat byte-enables from be_of_beat.
    task automatic set_line(input logic [63:0] base, input logic [63:0] be_of_beat, input logic [ID_W-1:0] id);
        for (int k = 0; k < BEATS; k++) begin
            line_data_i[k*MEM_DATA_W +: MEM_DATA_W] = base + 64'(k);
            line_be_i[k*8 +: 8] = be_of_beat[k*8 +: 8];
        end
        line_id_i = id;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; line_valid_i = 1'b0; beat_ready_i = 1'b0;
        line_data_i = '0; line_be_i = '0; line_id_i = '0;
        step();
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", beat_valid_o); end
        compared++;
        if (line_ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", line_ready_o); end
        compared++;
        if (busy_o !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        compared++;
        if (beat_last_o !== 1'b0) begin mismatched++; $display("FAIL reset_last: got %b want 0", beat_last_o); end
        @(negedge clk); rst_ni = 1'b1;
        step();
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_release_valid: got %b want 0", beat_valid_o); end
    endtask

    task automatic test_reset_mid_line;
        @(negedge clk);
        set_line(64'h30, {8{8'hFF}}, 4'd7);
        line_valid_i = 1'b1; beat_ready_i = 1'b1;
        step();
        line_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) step();
        compared++;
        if (beat_data_o !== 64'h33) begin mismatched++; $display("FAIL rst_mid_pre_beat3: got %h want 33", beat_data_o); end
        rst_ni = 1'b0;
        #1;
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL rst_mid_valid: got %b want 0", beat_valid_o); end
        compared++;
        if (line_ready_o !== 1'b1) begin mismatched++; $display("FAIL rst_mid_ready: got %b want 1", line_ready_o); end
        @(negedge clk); rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            compared++;
            if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL rst_mid_no_beats cyc %0d: got %b want 0", c, beat_valid_o); end
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        set_line(64'h0, {8{8'hFF}}, 4'd5);
        line_valid_i = 1'b1; beat_ready_i = 1'b1;
        #1;
        compared++;
        if (line_ready_o !== 1'b1) begin mismatched++; $display("FAIL basic_ready_idle: got %b want 1", line_ready_o); end
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL basic_valid_at_fire: got %b want 0", beat_valid_o); end
        @(negedge clk); line_valid_i = 1'b0; #1;
        for (int k = 0; k < BEATS; k++) begin
            compared++;
            if (beat_valid_o !== 1'b1) begin mismatched++; $display("FAIL basic_valid beat %0d: got %b want 1", k, beat_valid_o); end
            compared++;
            if (beat_data_o !== 64'(k)) begin mismatched++; $display("FAIL basic_data beat %0d: got %h want %h", k, beat_data_o, 64'(k)); end
            compared++;
            if (beat_id_o !== 4'd5) begin mismatched++; $display("FAIL basic_id beat %0d: got %0d want 5", k, beat_id_o); end
            compared++;
            if (beat_be_o !== 8'hFF) begin mismatched++; $display("FAIL basic_be beat %0d: got %h want ff", k, beat_be_o); end
            compared++;
            if (beat_last_o !== (k == 7)) begin mismatched++; $display("FAIL basic_last beat %0d: got %b want %b", k, beat_last_o, k == 7); end
            step();
        end
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL basic_idle_after: got %b want 0", beat_valid_o); end
    endtask

    task automatic test_backpressure;
        int n;
        n = 0;
        @(negedge clk);
        set_line(64'hA0, 64'h8877665544332211, 4'd9);
        line_valid_i = 1'b1; beat_ready_i = 1'b0;
        @(negedge clk); line_valid_i = 1'b0;
        for (int c = 0; c < 40 && n < BEATS; c++) begin
            beat_ready_i = (c % 3 == 0);
            #1;
            compared++;
            if (beat_valid_o !== 1'b1) begin mismatched++; $display("FAIL bp_valid cyc %0d: got %b want 1", c, beat_valid_o); end
            compared++;
            if (beat_data_o !== 64'hA0 + 64'(n)) begin mismatched++; $display("FAIL bp_data cyc %0d: got %h want %h", c, beat_data_o, 64'hA0 + 64'(n)); end
            compared++;
            if (beat_be_o !== 8'(17 * (n + 1))) begin mismatched++; $display("FAIL bp_be cyc %0d: got %h want %h", c, beat_be_o, 8'(17 * (n + 1))); end
            compared++;
            if (beat_last_o !== (n == 7)) begin mismatched++; $display("FAIL bp_last cyc %0d: got %b want %b", c, beat_last_o, n == 7); end
            if (beat_valid_o && beat_ready_i) n++;
            @(negedge clk);
        end
        compared++;
        if (n != BEATS) begin mismatched++; $display("FAIL bp_count: got %0d beats want 8", n); end
        beat_ready_i = 1'b1; #1;
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL bp_idle_after: got %b want 0", beat_valid_o); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_data;
        @(negedge clk);
        set_line(64'h100, {8{8'hFF}}, 4'd1);
        line_valid_i = 1'b1; beat_ready_i = 1'b1;
        #1;
        compared++;
        if (line_ready_o !== 1'b1) begin mismatched++; $display("FAIL b2b_first_ready: got %b want 1", line_ready_o); end
        @(negedge clk);
        set_line(64'h200, {8{8'hFF}}, 4'd2);
        for (int i = 0; i < 2 * BEATS; i++) begin
            if (i == BEATS) line_valid_i = 1'b0;
            #1;
            exp_data = (i < BEATS) ? 64'h100 + 64'(i) : 64'h200 + 64'(i - BEATS);
            compared++;
            if (beat_valid_o !== 1'b1) begin mismatched++; $display("FAIL b2b_valid cyc %0d: got %b want 1", i, beat_valid_o); end
            compared++;
            if (beat_data_o !== exp_data) begin mismatched++; $display("FAIL b2b_data cyc %0d: got %h want %h", i, beat_data_o, exp_data); end
            compared++;
            if (beat_id_o !== ((i < BEATS) ? 4'd1 : 4'd2)) begin mismatched++; $display("FAIL b2b_id cyc %0d: got %0d", i, beat_id_o); end
            compared++;
            if (beat_last_o !== (i % BEATS == BEATS - 1)) begin mismatched++; $display("FAIL b2b_last cyc %0d: got %b", i, beat_last_o); end
            compared++;
            if (line_ready_o !== (i == BEATS - 1 || i == 2 * BEATS - 1)) begin mismatched++; $display("FAIL b2b_line_ready cyc %0d: got %b", i, line_ready_o); end
            @(negedge clk);
        end
        #1;
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_after: got %b want 0", beat_valid_o); end
    endtask

    task automatic test_line_stall;
        int b_beats;
        b_beats = 0;
        @(negedge clk);
        set_line(64'h300, {8{8'hFF}}, 4'd3);
        line_valid_i = 1'b1; beat_ready_i = 1'b1;
        @(negedge clk); line_valid_i = 1'b0;
        for (int i = 0; i < 2 * BEATS; i++) begin
            if (i == 2) begin
                set_line(64'h400, {8{8'hFF}}, 4'd4);
                line_valid_i = 1'b1;
            end
            if (i == BEATS) line_valid_i = 1'b0;
            #1;
            compared++;
            if (line_ready_o !== (i == BEATS - 1 || i == 2 * BEATS - 1)) begin mismatched++; $display("FAIL stall_line_ready cyc %0d: got %b", i, line_ready_o); end
            compared++;
            if (beat_id_o !== ((i < BEATS) ? 4'd3 : 4'd4)) begin mismatched++; $display("FAIL stall_id cyc %0d: got %0d", i, beat_id_o); end
            if (beat_valid_o && beat_id_o == 4'd4) b_beats++;
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++;
            if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL stall_no_dup cyc %0d: got %b want 0", c, beat_valid_o); end
            @(negedge clk);
        end
        compared++;
        if (b_beats != BEATS) begin mismatched++; $display("FAIL stall_second_count: got %0d want 8", b_beats); end
    endtask

    task automatic test_sparse_be;
        @(negedge clk);
        set_line(64'h500, 64'h0000_0F00_0030_0000, 4'd6);
        line_valid_i = 1'b1; beat_ready_i = 1'b1;
        @(negedge clk); line_valid_i = 1'b0; #1;
`ifdef HPDCACHE_FLUSH_SER_SKIP_CLEAN_BEATS_EN
        compared++;
        if (beat_data_o !== 64'h502 || beat_be_o !== 8'h30 || beat_last_o !== 1'b0) begin
            mismatched++; $display("FAIL skip_first: got data %h be %h last %b want 502 30 0", beat_data_o, beat_be_o, beat_last_o);
        end
        step();
        compared++;
        if (beat_data_o !== 64'h505 || beat_be_o !== 8'h0F || beat_last_o !== 1'b1) begin
            mismatched++; $display("FAIL skip_second: got data %h be %h last %b want 505 0f 1", beat_data_o, beat_be_o, beat_last_o);
        end
        step();
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL skip_idle_after: got %b want 0", beat_valid_o); end
        @(negedge clk);
        set_line(64'h600, 64'h0, 4'd8);
        line_valid_i = 1'b1;
        @(negedge clk); line_valid_i = 1'b0; #1;
        compared++;
        if (beat_valid_o !== 1'b1 || beat_data_o !== 64'h600 || beat_be_o !== 8'h00 || beat_last_o !== 1'b1) begin
            mismatched++; $display("FAIL skip_empty: got valid %b data %h be %h last %b want 1 600 00 1", beat_valid_o, beat_data_o, beat_be_o, beat_last_o);
        end
        step();
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL skip_empty_idle: got %b want 0", beat_valid_o); end
`else
        for (int k = 0; k < BEATS; k++) begin
            compared++;
            if (beat_data_o !== 64'h500 + 64'(k) || beat_last_o !== (k == 7)) begin
                mismatched++; $display("FAIL sparse_beat %0d: got data %h last %b", k, beat_data_o, beat_last_o);
            end
            compared++;
            if (beat_be_o !== ((k == 2) ? 8'h30 : (k == 5) ? 8'h0F : 8'h00)) begin
                mismatched++; $display("FAIL sparse_be beat %0d: got %h", k, beat_be_o);
            end
            step();
        end
        compared++;
        if (beat_valid_o !== 1'b0) begin mismatched++; $display("FAIL sparse_idle_after: got %b want 0", beat_valid_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_line();
        test_backpressure();
        test_back_to_back();
        test_line_stall();
        test_sparse_be();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
